// File: rtl/pipelined_instruction_decoder.sv
// LEGv8 decode stage: registers control word, register fields, PC and extended immediate.
// Latency: 1 cycle from the accept edge to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled bundle holds bit-stable.
//
// Ports:
//   clk, reset (sync, active-high), flush (kills held output and this cycle's accept)
//   in_valid/in_ready/instruction/in_pc    : fetch side handshake
//   out_valid/out_ready/out_pc + controls  : register-read side handshake and bundle
//   illegal / illegal_cnt                  : illegal-encoding flag and saturating count
module pipelined_instruction_decoder #(
    parameter int IMM_W  = 64,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic              Reg2Loc,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              SetFlags,
    output logic              UnCondBr,
    output logic              CondBr,
    output logic              CbzBr,
    output logic              BrReg,
    output logic              Link,
    output logic [2:0]        ALUop,
    output logic [4:0]        Rn,
    output logic [4:0]        Rm,
    output logic [4:0]        Rd,
    output logic [3:0]        cond,
    output logic [5:0]        shamt,
    output logic [IMM_W-1:0]  imm,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    // The widest immediate is the 26-bit branch offset shifted left by two.
    if (IMM_W < 28) begin : g_imm_w_check
        $error("pipelined_instruction_decoder: IMM_W must be >= 28");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              reg2loc;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_write;
        logic              set_flags;
        logic              uncond_br;
        logic              cond_br;
        logic              cbz_br;
        logic              br_reg;
        logic              link;
        logic [2:0]        alu_op;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [4:0]        rd;
        logic [3:0]        cond;
        logic [5:0]        shamt;
        logic [IMM_W-1:0]  imm;
        logic              illegal;
    } bundle_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

    bundle_t            bundle_q, bundle_d, dec_bundle;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
    logic               accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Combinational decode of the incoming word; first match wins.
    always_comb begin
        dec_bundle         = '0;
        dec_bundle.pc      = in_pc;
        dec_bundle.rd      = instruction[4:0];
        dec_bundle.rn      = instruction[9:5];
        dec_bundle.rm      = instruction[20:16];
        dec_bundle.reg2loc = 1'b1;

        if (instruction[31:22] == 10'b1001000100) begin          // ADDI
            dec_bundle.alu_src   = 1'b1;
            dec_bundle.reg_write = 1'b1;
            dec_bundle.alu_op    = ALU_ADD;
            dec_bundle.imm       = IMM_W'(instruction[21:10]);
        end else if (instruction[31:21] == 11'b10101011000) begin // ADDS
            dec_bundle.reg_write = 1'b1;
            dec_bundle.set_flags = 1'b1;
            dec_bundle.alu_op    = ALU_ADD;
            dec_bundle.shamt     = instruction[15:10];
        end else if (instruction[31:21] == 11'b11101011000) begin // SUBS
            dec_bundle.reg_write = 1'b1;
            dec_bundle.set_flags = 1'b1;
            dec_bundle.alu_op    = ALU_SUB;
            dec_bundle.shamt     = instruction[15:10];
        end else if (instruction[31:21] == 11'b11111000010) begin // LDUR
            dec_bundle.alu_src    = 1'b1;
            dec_bundle.mem_to_reg = 1'b1;
            dec_bundle.reg_write  = 1'b1;
            dec_bundle.alu_op     = ALU_ADD;
            dec_bundle.imm        = IMM_W'($signed(instruction[20:12]));
        end else if (instruction[31:21] == 11'b11111000000) begin // STUR
            dec_bundle.reg2loc   = 1'b0;
            dec_bundle.alu_src   = 1'b1;
            dec_bundle.mem_write = 1'b1;
            dec_bundle.alu_op    = ALU_ADD;
            dec_bundle.imm       = IMM_W'($signed(instruction[20:12]));
        end else if (instruction[31:26] == 6'b000101) begin       // B
            dec_bundle.uncond_br = 1'b1;
            dec_bundle.imm       = IMM_W'($signed({instruction[25:0], 2'b00}));
        end else if (instruction[31:26] == 6'b100101) begin       // BL
            dec_bundle.uncond_br = 1'b1;
            dec_bundle.link      = 1'b1;
            dec_bundle.reg_write = 1'b1;
            dec_bundle.rd        = 5'd30;                         // link register
            dec_bundle.imm       = IMM_W'($signed({instruction[25:0], 2'b00}));
        end else if (instruction[31:24] == 8'b01010100) begin     // B.cond
            dec_bundle.cond_br = 1'b1;
            dec_bundle.cond    = instruction[3:0];
            dec_bundle.imm     = IMM_W'($signed({instruction[23:5], 2'b00}));
            dec_bundle.illegal = instruction[4];                  // reserved bit must be 0
        end else if (instruction[31:24] == 8'b10110100) begin     // CBZ
            dec_bundle.reg2loc = 1'b0;
            dec_bundle.cbz_br  = 1'b1;
            dec_bundle.alu_op  = ALU_PASS_B;
            dec_bundle.imm     = IMM_W'($signed({instruction[23:5], 2'b00}));
        end else if (instruction[31:21] == 11'b11010110000) begin // BR
            dec_bundle.br_reg = 1'b1;
            dec_bundle.alu_op = ALU_PASS_B;
        end else begin
            dec_bundle.illegal = 1'b1;
        end

        // An illegal bundle must never change architectural state or redirect fetch.
        if (dec_bundle.illegal) begin
            dec_bundle.reg_write = 1'b0;
            dec_bundle.mem_write = 1'b0;
            dec_bundle.set_flags = 1'b0;
            dec_bundle.uncond_br = 1'b0;
            dec_bundle.cond_br   = 1'b0;
            dec_bundle.cbz_br    = 1'b0;
            dec_bundle.br_reg    = 1'b0;
            dec_bundle.link      = 1'b0;
        end
    end

    // Next-state: flush beats accept; accept beats drain.
    always_comb begin
        bundle_d      = bundle_q;
        out_valid_d   = out_valid_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            bundle_d    = dec_bundle;
            out_valid_d = 1'b1;
            if (dec_bundle.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            bundle_q      <= '0;
            bundle_q.rn   <= 5'd31;
            bundle_q.rm   <= 5'd31;
            bundle_q.rd   <= 5'd31;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            bundle_q      <= bundle_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = bundle_q.pc;
    assign Reg2Loc     = bundle_q.reg2loc;
    assign ALUSrc      = bundle_q.alu_src;
    assign MemtoReg    = bundle_q.mem_to_reg;
    assign RegWrite    = bundle_q.reg_write;
    assign MemWrite    = bundle_q.mem_write;
    assign SetFlags    = bundle_q.set_flags;
    assign UnCondBr    = bundle_q.uncond_br;
    assign CondBr      = bundle_q.cond_br;
    assign CbzBr       = bundle_q.cbz_br;
    assign BrReg       = bundle_q.br_reg;
    assign Link        = bundle_q.link;
    assign ALUop       = bundle_q.alu_op;
    assign Rn          = bundle_q.rn;
    assign Rm          = bundle_q.rm;
    assign Rd          = bundle_q.rd;
    assign cond        = bundle_q.cond;
    assign shamt       = bundle_q.shamt;
    assign imm         = bundle_q.imm;
    assign illegal     = bundle_q.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Directed bench for the LEGv8 decode stage: decode table, handshake stalls,
// flush, reset-while-stalled and illegal-counter saturation (narrow-counter copy).
module tb_pipelined_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instruction;
    logic [63:0] in_pc;

    logic        in_ready, out_valid;
    logic [63:0] out_pc, imm;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, SetFlags;
    logic        UnCondBr, CondBr, CbzBr, BrReg, Link, illegal;
    logic [2:0]  ALUop;
    logic [4:0]  Rn, Rm, Rd;
    logic [3:0]  cond;
    logic [5:0]  shamt;
    logic [15:0] illegal_cnt;

    // Second copy with a 2-bit counter, only its counter is inspected.
    logic        s_in_ready, s_out_valid;
    logic [63:0] s_out_pc, s_imm;
    logic        s_Reg2Loc, s_ALUSrc, s_MemtoReg, s_RegWrite, s_MemWrite, s_SetFlags;
    logic        s_UnCondBr, s_CondBr, s_CbzBr, s_BrReg, s_Link, s_illegal;
    logic [2:0]  s_ALUop;
    logic [4:0]  s_Rn, s_Rm, s_Rd;
    logic [3:0]  s_cond;
    logic [5:0]  s_shamt;
    logic [1:0]  s_illegal_cnt;

    always #5 clk = ~clk;

    pipelined_instruction_decoder dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .SetFlags(SetFlags), .UnCondBr(UnCondBr),
        .CondBr(CondBr), .CbzBr(CbzBr), .BrReg(BrReg), .Link(Link), .ALUop(ALUop),
        .Rn(Rn), .Rm(Rm), .Rd(Rd), .cond(cond), .shamt(shamt), .imm(imm),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    pipelined_instruction_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .instruction(instruction), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .Reg2Loc(s_Reg2Loc), .ALUSrc(s_ALUSrc), .MemtoReg(s_MemtoReg),
        .RegWrite(s_RegWrite), .MemWrite(s_MemWrite), .SetFlags(s_SetFlags), .UnCondBr(s_UnCondBr),
        .CondBr(s_CondBr), .CbzBr(s_CbzBr), .BrReg(s_BrReg), .Link(s_Link), .ALUop(s_ALUop),
        .Rn(s_Rn), .Rm(s_Rm), .Rd(s_Rd), .cond(s_cond), .shamt(s_shamt), .imm(s_imm),
        .illegal(s_illegal), .illegal_cnt(s_illegal_cnt)
    );

    // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, SetFlags, UnCondBr, CondBr, CbzBr, BrReg, Link}
    logic [10:0] ctrl;
    assign ctrl = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, SetFlags,
                   UnCondBr, CondBr, CbzBr, BrReg, Link};

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
        logic [14:0] regs;   // {Rn, Rm, Rd}
        logic [63:0] imm;
        logic [2:0]  aluop;
        logic [3:0]  cond;
        logic [5:0]  shamt;
        logic        illegal;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0]  = '{32'h9101F96F, 11'b11010000000, {5'd11, 5'd1,  5'd15}, 64'd126,
                    3'b010, 4'd0, 6'd0, 1'b0, 16'd0};                              // ADDI
        vec[1]  = '{32'hAB031441, 11'b10010100000, {5'd2,  5'd3,  5'd1},  64'd0,
                    3'b010, 4'd0, 6'd5, 1'b0, 16'd0};                              // ADDS
        vec[2]  = '{32'hEB031441, 11'b10010100000, {5'd2,  5'd3,  5'd1},  64'd0,
                    3'b011, 4'd0, 6'd5, 1'b0, 16'd0};                              // SUBS
        vec[3]  = '{32'hF85FF3E0, 11'b11110000000, {5'd31, 5'd31, 5'd0},  64'hFFFF_FFFF_FFFF_FFFF,
                    3'b010, 4'd0, 6'd0, 1'b0, 16'd0};                              // LDUR imm9=-1
        vec[4]  = '{32'hF80932AA, 11'b01001000000, {5'd21, 5'd9,  5'd10}, 64'd147,
                    3'b010, 4'd0, 6'd0, 1'b0, 16'd0};                              // STUR
        vec[5]  = '{32'h17FFFFFF, 11'b10000010000, {5'd31, 5'd31, 5'd31}, 64'hFFFF_FFFF_FFFF_FFFC,
                    3'b000, 4'd0, 6'd0, 1'b0, 16'd0};                              // B -1
        vec[6]  = '{32'h94000001, 11'b10010010001, {5'd0,  5'd0,  5'd30}, 64'd4,
                    3'b000, 4'd0, 6'd0, 1'b0, 16'd0};                              // BL +1
        vec[7]  = '{32'h54FFFFC1, 11'b10000001000, {5'd30, 5'd31, 5'd1},  64'hFFFF_FFFF_FFFF_FFF8,
                    3'b000, 4'd1, 6'd0, 1'b0, 16'd0};                              // B.NE -2
        vec[8]  = '{32'hB4000105, 11'b00000000100, {5'd8,  5'd0,  5'd5},  64'd32,
                    3'b000, 4'd0, 6'd0, 1'b0, 16'd0};                              // CBZ +8
        vec[9]  = '{32'hD61F03C0, 11'b10000000010, {5'd30, 5'd31, 5'd0},  64'd0,
                    3'b000, 4'd0, 6'd0, 1'b0, 16'd0};                              // BR X30
        vec[10] = '{32'h00000000, 11'b10000000000, {5'd0,  5'd0,  5'd0},  64'd0,
                    3'b000, 4'd0, 6'd0, 1'b1, 16'd1};                              // all-zero
        vec[11] = '{32'h54000010, 11'b10000000000, {5'd0,  5'd0,  5'd16}, 64'd0,
                    3'b000, 4'd0, 6'd0, 1'b1, 16'd2};                              // B.cond bit4=1

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = 32'h0; in_pc = 64'h0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_regs", 64'({Rn, Rm, Rd}), 64'({5'd31, 5'd31, 5'd31}));
        check("rst_ctrl", 64'({ctrl, ALUop, cond, shamt, illegal}), 64'd0);
        check("rst_imm_pc", imm | out_pc, 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Streamed decode table, one accept per cycle.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; instruction = vec[i].instr; in_pc = 64'h1000 + 64'(4 * i);
            tick();
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_pc", i), out_pc, 64'h1000 + 64'(4 * i));
            check($sformatf("v%0d_ctrl", i), 64'(ctrl), 64'(vec[i].ctrl));
            check($sformatf("v%0d_regs", i), 64'({Rn, Rm, Rd}), 64'(vec[i].regs));
            check($sformatf("v%0d_imm", i), imm, vec[i].imm);
            check($sformatf("v%0d_misc", i), 64'({ALUop, cond, shamt, illegal}),
                  64'({vec[i].aluop, vec[i].cond, vec[i].shamt, vec[i].illegal}));
            check($sformatf("v%0d_cnt", i), 64'(illegal_cnt), 64'(vec[i].cnt));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Flush with a simultaneous accept of an illegal word: nothing lands, count unchanged.
        in_valid = 1'b1; instruction = 32'h0; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_accept_valid", 64'(out_valid), 64'd0);
        check("flush_accept_cnt", 64'(illegal_cnt), 64'd2);

        // Flush kills a held (stalled) bundle.
        in_valid = 1'b1; instruction = 32'h9101F96F; in_pc = 64'h2000;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        check("flush_held_valid", 64'(out_valid), 64'd0);

        // Backpressure: hold ADDI for 5 cycles while ADDS waits at the input.
        in_valid = 1'b1; instruction = 32'h9101F96F; in_pc = 64'h3000;
        tick();
        out_ready = 1'b0; instruction = 32'hAB031441; in_pc = 64'h3004;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("stall%0d_hold", c), 64'({out_valid, Rd, Rn, ctrl}),
                  64'({1'b1, 5'd15, 5'd11, 11'b11010000000}));
            check($sformatf("stall%0d_pc_imm", c), out_pc ^ imm, 64'h3000 ^ 64'd126);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("release_next", 64'({out_valid, Rd, SetFlags}), 64'({1'b1, 5'd1, 1'b1}));
        check("release_pc", out_pc, 64'h3004);
        tick();
        check("release_no_dup", 64'(out_valid), 64'd0);

        // Reset pulse while stalled drops the held bundle.
        in_valid = 1'b1; instruction = 32'hF80932AA; in_pc = 64'h4000;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b1;
        check("stall_rst_valid", 64'(out_valid), 64'd0);
        check("stall_rst_regs", 64'({Rn, Rm, Rd}), 64'({5'd31, 5'd31, 5'd31}));
        check("stall_rst_cnt", 64'(illegal_cnt), 64'd0);

        // Five illegal accepts: wide counter reaches 5, 2-bit counter sticks at 3.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; instruction = (k % 2 == 0) ? 32'h00000000 : 32'h54000010;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("sat_wide_cnt", 64'(illegal_cnt), 64'd5);
        check("sat_narrow_cnt", 64'(s_illegal_cnt), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
LEGv8 decode stage for the pipelined CPU. Accepts fetched instructions over a valid/ready handshake and registers the full control word plus register fields and a sign-extended, pre-shifted immediate. Covers ADDI, ADDS, SUBS, B, BL, B.cond, BR, CBZ, LDUR and STUR, and flags illegal encodings. Sits between fetch and register-read, with a branch-resolution flush input.

Parameters:
IMM_W, 64, width of the immediate output; must be >= 28 (elaboration error otherwise).
ADDR_W, 64, width of the PC carried with each instruction.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
flush  in  1  kills the held output and any instruction accepted this cycle.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  decoder can accept this cycle.
instruction  in  32  raw instruction word.
in_pc  in  ADDR_W  PC of the instruction.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream accepts the bundle.
out_pc  out  ADDR_W  registered PC.
Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, SetFlags  out  1 each  datapath controls.
UnCondBr, CondBr, CbzBr, BrReg, Link  out  1 each  branch type (B/BL, B.cond, CBZ, BR, BL).
ALUop  out  3  000 pass-B, 010 add, 011 subtract.
Rn, Rm, Rd  out  5 each  register fields.
cond  out  4  B.cond condition.
shamt  out  6  R-type shift amount.
imm  out  IMM_W  sign- or zero-extended immediate.
illegal  out  1  bundle is an unrecognised or illegal encoding.
illegal_cnt  out  CNT_W  saturating count of illegal bundles accepted.

Behaviour:
- Single register stage; latency is 1 cycle from the accept edge to out_valid.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready && !flush.
- If out_valid && !out_ready, every output holds bit-stable.
- On accept, load the decoded bundle and set out_valid=1.
- Else if out_ready, clear out_valid. Data outputs may hold stale values.
- flush=1: next cycle out_valid=0 and illegal_cnt is unchanged; flush wins over a simultaneous accept.
- reset=1: out_valid=0; all 1-bit controls, ALUop, cond, shamt, imm and illegal are 0; Rn=Rm=Rd=31; out_pc=0; illegal_cnt=0. Reset mid-stall drops the held bundle.
- Register fields: Rd=[4:0], Rn=[9:5], Rm=[20:16]. Exception: BL forces Rd=30 and RegWrite=1.
- Reg2Loc: 0 for STUR and CBZ (second read port uses [4:0]); 1 otherwise.
- Decode match priority follows list order; anything else is illegal:
  - ADDI, [31:22]=1001000100: ALUSrc=1, RegWrite=1, ALUop=010; imm = zero-extended [21:10].
  - ADDS, [31:21]=10101011000: RegWrite=1, SetFlags=1, ALUop=010; shamt=[15:10].
  - SUBS, [31:21]=11101011000: as ADDS with ALUop=011.
  - LDUR, [31:21]=11111000010: ALUSrc=1, MemtoReg=1, RegWrite=1, ALUop=010; imm = sign-extended [20:12].
  - STUR, [31:21]=11111000000: ALUSrc=1, MemWrite=1, ALUop=010; imm = sign-extended [20:12].
  - B, [31:26]=000101: UnCondBr=1; imm = sign-extended ([25:0] << 2).
  - BL, [31:26]=100101: as B, plus Link=1.
  - B.cond, [31:24]=01010100: CondBr=1; cond=[3:0]; imm = sign-extended ([23:5] << 2). Illegal if [4]=1.
  - CBZ, [31:24]=10110100: CbzBr=1, ALUop=000; imm = sign-extended ([23:5] << 2).
  - BR, [31:21]=11010110000: BrReg=1, ALUop=000.
- Illegal bundle: illegal=1, and RegWrite, MemWrite, SetFlags and all branch controls are forced to 0.
- illegal_cnt increments on each accepted illegal instruction and saturates at all-ones.

Test Plan:
- Reset then ADDI 0x9101F96F, out_ready=1 -> one cycle later: out_valid=1, Rd=15, Rn=11, imm=126, ALUSrc=1, RegWrite=1, ALUop=010.
- B 0x17FFFFFF -> UnCondBr=1, imm=0xFFFF_FFFF_FFFF_FFFC. BL 0x94000001 -> Link=1, Rd=30, RegWrite=1, imm=4.
- LDUR with imm9=0x1FF, Rn=31, Rd=0 -> imm=-1, MemtoReg=1. STUR 0xF8093 2AA -> Reg2Loc=0, MemWrite=1, RegWrite=0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable. Releasing out_ready -> the next instruction appears one cycle later with no loss or duplication.
- flush asserted together with an accept -> next cycle out_valid=0. A reset pulse while stalled -> out_valid=0, Rn=Rm=Rd=31.
- Instructions 0x00000000 and B.cond with [4]=1 -> illegal=1, RegWrite=MemWrite=0, illegal_cnt counts 1 then 2. With CNT_W=2 and 5 illegals -> illegal_cnt saturates at 3.
